regfile_nrd: RTL and testbench
==============================

Name: regfile_nrd

Overview:
- Parametrised CPU register file: DEPTH entries of WIDTH bits, one write port, NRD independent read ports.
- Each read port is a DEPTH:1 word-select with same-cycle write-through bypass.
- Optional registered read stage, set by the READ_REG parameter.
- Built-in sequential bulk-clear engine. Sits in the decode stage and feeds the operand-forwarding muxes.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 32, number of entries; 2 <= DEPTH <= 2**ADDR_W.
- ADDR_W, 5, address width per port.
- NRD, 2, number of read ports (1..4).
- READ_REG, 0: 0 = combinational read; 1 = one-cycle registered read.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  WIDTH  write data.
- rd_addr  in  NRD*ADDR_W  packed read addresses; port i = bits [i*ADDR_W +: ADDR_W].
- rd_data  out  NRD*WIDTH  packed read data; port i = bits [i*WIDTH +: WIDTH].
- clr_req  in  1  single-cycle pulse: start bulk clear.
- busy  out  1  high while clear engine runs.
- wr_err  out  1  one-cycle pulse: write dropped.

Behaviour:
- Reset (rst_n low, asynchronous): all entries = 0, state = IDLE, clear counter = 0, busy = 0, wr_err = 0, rd_data registers = 0 (READ_REG=1). Release is synchronous to clk.
- Write:
  - In IDLE, wr_en=1 with wr_addr < DEPTH writes mem[wr_addr] <= wr_data on the rising edge.
  - wr_addr >= DEPTH: write ignored, wr_err=1 next cycle.
- Read value per port i, v_i:
  - rd_addr_i >= DEPTH -> 0.
  - else if wr_en && !busy && wr_addr == rd_addr_i && wr_addr < DEPTH -> wr_data (bypass).
  - else -> mem[rd_addr_i].
- Read latency:
  - READ_REG=0: rd_data_i = v_i combinationally, zero latency.
  - READ_REG=1: rd_data_i <= v_i on each edge, one-cycle latency; updates every cycle (no enable).
- All ports are independent; any number of ports may select the same address.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR on the edge sampling clr_req=1; counter <= 0.
  - In CLEAR, each edge: mem[counter] <= 0, counter++. After the edge clearing entry DEPTH-1, go to IDLE.
  - busy = (state == CLEAR), registered. High for exactly DEPTH cycles.
- Clear boundary conditions:
  - clr_req while busy: ignored; clear does not restart.
  - wr_en while busy: write dropped, bypass disabled, wr_err=1 the following cycle.
  - wr_en in the same IDLE cycle as clr_req: write performed, then zeroed by the clear.
  - Reads while busy return current mem contents (mix of cleared and not-yet-cleared entries).
  - rst_n asserted mid-clear: immediate return to reset state; the clear is abandoned.
- wr_err is registered; only ever a one-cycle pulse per dropped write.

Optional Feature:
- Macro RF_ZERO_REG_EN.
- Defined:
  - Entry 0 is hardwired zero; reads of address 0 always return 0, including through the bypass.
  - Writes to address 0 are silently discarded; no wr_err.
- Undefined: entry 0 is an ordinary register.

Test Plan:
- Reset then read: rst_n low 2 cycles, read all 32 addresses on ports 0/1 -> all 0, busy=0, wr_err=0.
- Write/readback: write 0xDEADBEEF to addr 7, next cycle rd_addr0=7 -> 0xDEADBEEF (READ_REG=0), one cycle later for READ_REG=1.
- Bypass:
  - Same cycle wr_en=1, wr_addr=12, wr_data=0x12345678, rd_addr0=rd_addr1=12 -> both ports 0x12345678 in that cycle (READ_REG=0).
  - With RF_ZERO_REG_EN, write 0xFFFFFFFF to addr 0 -> reads 0, wr_err=0.
- Bulk clear:
  - Fill all entries with index+1, pulse clr_req -> busy high exactly 32 cycles.
  - A write to addr 3 during busy is dropped with a wr_err pulse.
  - A second clr_req mid-clear is ignored.
  - After busy falls, all entries read 0.
- Out-of-range, DEPTH=20: write to addr 25 -> wr_err pulse, no entry changed; rd_addr=25 -> 0.
- Reset mid-clear: assert rst_n low at clear cycle 10 -> busy=0 immediately, all entries 0; new clr_req afterwards runs the full 32 cycles.

Source files
------------

// File: rtl/regfile_nrd.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_nrd: DEPTH x WIDTH register file, one write port and NRD read    |
// | ports with write-through bypass, optional read register, and a bulk-     |
// | clear engine. Macro RF_ZERO_REG_EN hardwires entry 0 to zero.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module regfile_nrd #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int NRD      = 2,
    parameter int READ_REG = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    output logic [NRD*WIDTH-1:0]  rd_data,
    input  logic                  clr_req,
    output logic                  busy,
    output logic                  wr_err
);

    localparam logic [0:0]        c_S_IDLE  = 1'b0;
    localparam logic [0:0]        c_S_CLEAR = 1'b1;
    localparam logic [ADDR_W:0]   c_DEPTH   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] c_LAST    = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] c_ONE     = ADDR_W'(1);

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_wr_err;
    logic [WIDTH-1:0]  r_mem [DEPTH];

    logic w_in_range;
    logic w_wr_ok;
    logic w_wr_drop;

    assign w_in_range = ({1'b0, wr_addr} < c_DEPTH);
`ifdef RF_ZERO_REG_EN
    // Entry 0 never takes a write, so it stays at its reset/clear value of 0.
    assign w_wr_ok = wr_en && (r_state == c_S_IDLE) && w_in_range && (wr_addr != '0);
`else
    assign w_wr_ok = wr_en && (r_state == c_S_IDLE) && w_in_range;
`endif
    assign w_wr_drop = wr_en && ((r_state == c_S_CLEAR) || !w_in_range);

    assign busy   = (r_state == c_S_CLEAR);
    assign wr_err = r_wr_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_S_IDLE;
            r_cnt    <= '0;
            r_wr_err <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_wr_err <= w_wr_drop;
            case (r_state)
                c_S_IDLE: begin
                    if (w_wr_ok) begin
                        r_mem[wr_addr] <= wr_data;
                    end
                    if (clr_req) begin
                        r_state <= c_S_CLEAR;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_mem[r_cnt] <= '0;
                    r_cnt        <= r_cnt + c_ONE;
                    if (r_cnt == c_LAST) begin
                        r_state <= c_S_IDLE;
                    end
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NRD; gi++) begin : g_port
            logic [ADDR_W-1:0] w_addr;
            logic [WIDTH-1:0]  w_val;

            assign w_addr = rd_addr[gi*ADDR_W +: ADDR_W];

            // Addresses with no matching entry fall through to zero.
            always_comb begin
                w_val = '0;
                for (int j = 0; j < DEPTH; j++) begin
                    if (w_addr == ADDR_W'(j)) begin
                        w_val = r_mem[j];
                    end
                end
                if (w_wr_ok && (wr_addr == w_addr)) begin
                    w_val = wr_data;
                end
            end

            if (READ_REG != 0) begin : g_rdreg
                logic [WIDTH-1:0] r_rd;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_rd <= '0;
                    end else begin
                        r_rd <= w_val;
                    end
                end
                assign rd_data[gi*WIDTH +: WIDTH] = r_rd;
            end else begin : g_rdcomb
                assign rd_data[gi*WIDTH +: WIDTH] = w_val;
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_regfile_nrd.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_regfile_nrd: directed bench for regfile_nrd (32-entry combinational   |
// | instance and 20-entry registered-read instance).                         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_regfile_nrd;

`ifdef RF_ZERO_REG_EN
    localparam logic [31:0] c_R0_BYP  = 32'h0;
    localparam logic [31:0] c_R0_FILL = 32'h0;
`else
    localparam logic [31:0] c_R0_BYP  = 32'hFFFF_FFFF;
    localparam logic [31:0] c_R0_FILL = 32'h1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        a_wr_en, a_clr, a_busy, a_wr_err;
    logic [4:0]  a_wr_addr;
    logic [31:0] a_wr_data;
    logic [9:0]  a_rd_addr;
    logic [63:0] a_rd_data;
    logic        b_wr_en, b_clr, b_busy, b_wr_err;
    logic [4:0]  b_wr_addr;
    logic [31:0] b_wr_data;
    logic [9:0]  b_rd_addr;
    logic [63:0] b_rd_data;

    regfile_nrd u_a (
        .clk(clk), .rst_n(rst_n), .wr_en(a_wr_en), .wr_addr(a_wr_addr),
        .wr_data(a_wr_data), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
        .clr_req(a_clr), .busy(a_busy), .wr_err(a_wr_err)
    );

    regfile_nrd #(.DEPTH(20), .READ_REG(1)) u_b (
        .clk(clk), .rst_n(rst_n), .wr_en(b_wr_en), .wr_addr(b_wr_addr),
        .wr_data(b_wr_data), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
        .clr_req(b_clr), .busy(b_busy), .wr_err(b_wr_err)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] v);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard_empty observed=%h expected=none", obs);
        end else begin
            chk(tag_q.pop_front(), obs, exp_q.pop_front());
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] a_rd(input int p);
        return a_rd_data[p*32 +: 32];
    endfunction

    function automatic logic [31:0] fillv(input int a);
        return (a == 0) ? c_R0_FILL : 32'(a + 1);
    endfunction

    task automatic a_write(input logic [4:0] ad, input logic [31:0] d);
        a_wr_en   = 1'b1;
        a_wr_addr = ad;
        a_wr_data = d;
        tick();
        a_wr_en   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        a_wr_en = 0; a_clr = 0; a_wr_addr = '0; a_wr_data = '0; a_rd_addr = '0;
        b_wr_en = 0; b_clr = 0; b_wr_addr = '0; b_wr_data = '0; b_rd_addr = '0;
        tick();
        tick();
        chk("rst_busy", 32'(a_busy), 32'h0);
        chk("rst_wr_err", 32'(a_wr_err), 32'h0);
        chk("rst_b_rdreg", b_rd_data[31:0], 32'h0);
        rst_n = 1'b1;

        for (int a = 0; a < 32; a++) begin
            a_rd_addr = {5'(31 - a), 5'(a)};
            push("rst_rd0", 32'h0);
            push("rst_rd1", 32'h0);
            #1;
            pop_chk(a_rd(0));
            pop_chk(a_rd(1));
        end

        // write then read back
        a_rd_addr = '0;
        a_write(5'd7, 32'hDEAD_BEEF);
        a_rd_addr = {5'd0, 5'd7};
        push("wr_readback", 32'hDEAD_BEEF);
        #1;
        pop_chk(a_rd(0));

        // same-cycle bypass on both ports
        a_wr_en = 1'b1; a_wr_addr = 5'd12; a_wr_data = 32'h1234_5678;
        a_rd_addr = {5'd12, 5'd12};
        push("bypass_p0", 32'h1234_5678);
        push("bypass_p1", 32'h1234_5678);
        #1;
        pop_chk(a_rd(0));
        pop_chk(a_rd(1));
        tick();
        a_wr_en = 1'b0;
        push("bypass_stored", 32'h1234_5678);
        #1;
        pop_chk(a_rd(0));

        // address 0 write
        a_wr_en = 1'b1; a_wr_addr = 5'd0; a_wr_data = 32'hFFFF_FFFF;
        a_rd_addr = {5'd0, 5'd0};
        push("r0_bypass", c_R0_BYP);
        #1;
        pop_chk(a_rd(0));
        tick();
        a_wr_en = 1'b0;
        chk("r0_wr_err", 32'(a_wr_err), 32'h0);
        push("r0_read", c_R0_BYP);
        #1;
        pop_chk(a_rd(0));

        // registered-read instance, DEPTH=20
        b_rd_addr = {5'd25, 5'd25};
        tick();
        b_wr_en = 1'b1; b_wr_addr = 5'd7; b_wr_data = 32'hDEAD_BEEF;
        tick();
        b_wr_addr = 5'd25; b_wr_data = 32'hFFFF_FFFF;
        b_rd_addr = {5'd25, 5'd7};
        push("b_rd7", 32'hDEAD_BEEF);
        push("b_rd25_oor", 32'h0);
        #1;
        chk("b_latency", b_rd_data[31:0], 32'h0);
        tick();
        b_wr_en = 1'b0;
        pop_chk(b_rd_data[31:0]);
        pop_chk(b_rd_data[63:32]);
        chk("b_oor_wr_err", 32'(b_wr_err), 32'h1);
        tick();
        chk("b_wr_err_pulse", 32'(b_wr_err), 32'h0);
        for (int a = 0; a < 20; a++) begin
            b_rd_addr = {5'(19 - a), 5'(a)};
            push("b_scan0", (a == 7) ? 32'hDEAD_BEEF : 32'h0);
            push("b_scan1", ((19 - a) == 7) ? 32'hDEAD_BEEF : 32'h0);
            tick();
            pop_chk(b_rd_data[31:0]);
            pop_chk(b_rd_data[63:32]);
        end

        // fill, then bulk clear
        for (int a = 0; a < 32; a++) begin
            a_write(5'(a), 32'(a + 1));
        end
        for (int a = 0; a < 32; a++) begin
            a_rd_addr = {5'((a + 5) % 32), 5'(a)};
            push("fill_p0", fillv(a));
            push("fill_p1", fillv((a + 5) % 32));
            #1;
            pop_chk(a_rd(0));
            pop_chk(a_rd(1));
        end
        a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
        chk("clr_busy_rise", 32'(a_busy), 32'h1);
        n = 0;
        while (a_busy && n < 100) begin
            if (n == 2) begin
                a_wr_en = 1'b1; a_wr_addr = 5'd3; a_wr_data = 32'hAAAA_5555;
                a_rd_addr = {5'd3, 5'd3};
                push("busy_no_bypass", 32'h4);
                #1;
                pop_chk(a_rd(0));
            end
            if (n == 3) begin
                a_wr_en = 1'b0;
                chk("busy_wr_err", 32'(a_wr_err), 32'h1);
                push("busy_write_dropped", 32'h4);
                #1;
                pop_chk(a_rd(0));
            end
            if (n == 4) chk("busy_wr_err_pulse", 32'(a_wr_err), 32'h0);
            if (n == 10) a_clr = 1'b1;
            if (n == 11) a_clr = 1'b0;
            tick();
            n++;
        end
        chk("busy_cycles", 32'(n), 32'd32);
        for (int a = 0; a < 32; a++) begin
            a_rd_addr = {5'(31 - a), 5'(a)};
            push("cleared_p0", 32'h0);
            push("cleared_p1", 32'h0);
            #1;
            pop_chk(a_rd(0));
            pop_chk(a_rd(1));
        end

        // write coincident with clr_req, then reset mid-clear
        a_write(5'd20, 32'h55);
        a_wr_en = 1'b1; a_wr_addr = 5'd5; a_wr_data = 32'hCAFE_0005; a_clr = 1'b1;
        tick();
        a_wr_en = 1'b0; a_clr = 1'b0;
        n = 0;
        while (a_busy && n < 10) begin
            if (n == 1) begin
                a_rd_addr = {5'd20, 5'd5};
                push("clr_same_cycle_wr", 32'hCAFE_0005);
                push("clr_pending_20", 32'h55);
                #1;
                pop_chk(a_rd(0));
                pop_chk(a_rd(1));
            end
            tick();
            n++;
        end
        chk("mid_clear_reached", 32'(n), 32'd10);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(a_busy), 32'h0);
        for (int a = 0; a < 32; a++) begin
            a_rd_addr = {5'(31 - a), 5'(a)};
            push("mid_rst_p0", 32'h0);
            push("mid_rst_p1", 32'h0);
            #1;
            pop_chk(a_rd(0));
            pop_chk(a_rd(1));
        end
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_busy", 32'(a_busy), 32'h0);
        a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
        n = 0;
        while (a_busy && n < 100) begin
            tick();
            n++;
        end
        chk("reclear_cycles", 32'(n), 32'd32);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
